// File: rtl/round_pkg.sv
// Shared definitions for the reaction-game round scorer.
// Contains the FSM state encoding and the two-digit BCD score helpers.
package round_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    // Two-digit BCD increment that sticks at 99 instead of wrapping.
    function automatic bcd2_t bcd_sat_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones == BCD_MAX) begin
            if (v.tens != BCD_MAX) begin
                r.ones = '0;
                r.tens = v.tens + 4'd1;
            end
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for a raw push button.
// A button already held when reset is released must be let go before it can fire.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q, prev_d;
    logic [1:0] valid_q, valid_d;

    // prev is held high until sync2 carries real post-reset data, so a held button reads as "no edge".
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        valid_d = {valid_q[0], 1'b1};
        prev_d  = valid_q[1] ? sync2_q : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b1;
            valid_q <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/round_scorer.sv
// Round controller and BCD scorer for the reaction game.
// Define ROUND_SCORER_STREAK_EN to add the hit-streak bonus and the streak port.
module round_scorer
    import round_pkg::*;
#(
    parameter int ROUND_TICKS = 10,
    parameter int MAX_LIVES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       submit,
    input  logic [2:0] match,
    output logic       new_round,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [1:0] lives,
    output logic [3:0] time_left,
    output logic       hit,
    output logic       miss,
    output logic       game_over,
    output logic [2:0] state
`ifdef ROUND_SCORER_STREAK_EN
    ,
    output logic [1:0] streak
`endif
);

    localparam logic [3:0] ROUND_TIME = 4'(ROUND_TICKS);
    localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);

    logic start_ev;
    logic submit_ev;

    edge_sync u_start_sync (
        .clk   (clk),
        .reset (reset),
        .din   (start),
        .pulse (start_ev)
    );

    edge_sync u_submit_sync (
        .clk   (clk),
        .reset (reset),
        .din   (submit),
        .pulse (submit_ev)
    );

    state_t     state_q, state_d;
    bcd2_t      score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic [3:0] time_left_q, time_left_d;
    logic       submitted_q, submitted_d;
    logic       new_round_q, new_round_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;
    logic       game_over_q, game_over_d;
`ifdef ROUND_SCORER_STREAK_EN
    logic [1:0] streak_q, streak_d;
`endif

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        lives_d     = lives_q;
        time_left_d = time_left_q;
        submitted_d = submitted_q;
        game_over_d = game_over_q;
        new_round_d = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
`ifdef ROUND_SCORER_STREAK_EN
        streak_d    = streak_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                new_round_d = 1'b1;
                time_left_d = ROUND_TIME;
                submitted_d = 1'b0;
                state_d     = ST_PLAY;
            end

            // A submit in the same cycle as a tick takes priority; the tick is simply lost.
            ST_PLAY: begin
                if (submit_ev) begin
                    submitted_d = 1'b1;
                    state_d     = ST_JUDGE;
                end else if (tick_1hz) begin
                    if (time_left_q <= 4'd1) begin
                        time_left_d = 4'd0;
                        submitted_d = 1'b0;
                        state_d     = ST_JUDGE;
                    end else begin
                        time_left_d = time_left_q - 4'd1;
                    end
                end
            end

            ST_JUDGE: begin
                if (submitted_q && (match == 3'b111)) begin
                    hit_d   = 1'b1;
                    score_d = bcd_sat_inc(score_q);
`ifdef ROUND_SCORER_STREAK_EN
                    if (streak_q >= 2'd2) begin
                        score_d = bcd_sat_inc(bcd_sat_inc(score_q));
                    end
                    if (streak_q != 2'd3) begin
                        streak_d = streak_q + 2'd1;
                    end
`endif
                    state_d = ST_ARM;
                end else begin
                    miss_d = 1'b1;
`ifdef ROUND_SCORER_STREAK_EN
                    streak_d = 2'd0;
`endif
                    if (lives_q <= 2'd1) begin
                        lives_d     = 2'd0;
                        game_over_d = 1'b1;
                        state_d     = ST_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = ST_ARM;
                    end
                end
            end

            ST_OVER: begin
                if (start_ev) begin
                    score_d     = '0;
                    lives_d     = LIVES_INIT;
                    game_over_d = 1'b0;
`ifdef ROUND_SCORER_STREAK_EN
                    streak_d    = 2'd0;
`endif
                    state_d     = ST_ARM;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            time_left_q <= 4'd0;
            submitted_q <= 1'b0;
            new_round_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
`ifdef ROUND_SCORER_STREAK_EN
            streak_q    <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            time_left_q <= time_left_d;
            submitted_q <= submitted_d;
            new_round_q <= new_round_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            game_over_q <= game_over_d;
`ifdef ROUND_SCORER_STREAK_EN
            streak_q    <= streak_d;
`endif
        end
    end

    assign new_round  = new_round_q;
    assign score_ones = score_q.ones;
    assign score_tens = score_q.tens;
    assign lives      = lives_q;
    assign time_left  = time_left_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign game_over  = game_over_q;
    assign state      = state_q;
`ifdef ROUND_SCORER_STREAK_EN
    assign streak     = streak_q;
`endif

endmodule

// File: tb/tb_round_scorer.sv
// Self-checking bench for round_scorer: vector table, hand-written corner sequences,
// and randomized rounds scored by a game-level reference model.
module tb_round_scorer;

    localparam int ROUND_TICKS = 10;
    localparam int MAX_LIVES   = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       start    = 1'b0;
    logic       submit   = 1'b0;
    logic [2:0] match    = 3'b000;
    logic       new_round;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [1:0] lives;
    logic [3:0] time_left;
    logic       hit;
    logic       miss;
    logic       game_over;
    logic [2:0] state;
`ifdef ROUND_SCORER_STREAK_EN
    logic [1:0] streak;
`endif

    int checkCount = 0;
    int errorCount = 0;
    int hitCount   = 0;
    int missCount  = 0;
    int nrCount    = 0;

    int mScore;
    int mLives;
    bit mOver;
`ifdef ROUND_SCORER_STREAK_EN
    int mStreak;
`endif

    typedef struct {
        logic [2:0] match;
        bit         useSubmit;
        bit         expHit;
        int         expScore;
        int         expLives;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    round_scorer #(
        .ROUND_TICKS (ROUND_TICKS),
        .MAX_LIVES   (MAX_LIVES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .start      (start),
        .submit     (submit),
        .match      (match),
        .new_round  (new_round),
        .score_ones (score_ones),
        .score_tens (score_tens),
        .lives      (lives),
        .time_left  (time_left),
        .hit        (hit),
        .miss       (miss),
        .game_over  (game_over),
        .state      (state)
`ifdef ROUND_SCORER_STREAK_EN
        ,
        .streak     (streak)
`endif
    );

    // Pulse counters let the stimulus tasks wait for events without racing the edge.
    always @(posedge clk) begin
        #1;
        if (hit === 1'b1) hitCount++;
        if (miss === 1'b1) missCount++;
        if (new_round === 1'b1) nrCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic int dutScore();
        return int'(score_tens) * 10 + int'(score_ones);
    endfunction

    task automatic modelNewGame();
        mScore = 0;
        mLives = MAX_LIVES;
        mOver  = 1'b0;
`ifdef ROUND_SCORER_STREAK_EN
        mStreak = 0;
`endif
    endtask

    task automatic modelJudge(input bit win);
        int gain;
        if (win) begin
            gain = 1;
`ifdef ROUND_SCORER_STREAK_EN
            if (mStreak >= 2) gain = 2;
            if (mStreak < 3) mStreak++;
`endif
            mScore = (mScore + gain > 99) ? 99 : mScore + gain;
        end else begin
`ifdef ROUND_SCORER_STREAK_EN
            mStreak = 0;
`endif
            mLives--;
            if (mLives == 0) mOver = 1'b1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, int'(state), 0);
        checkOutput({tag, "_score"}, dutScore(), 0);
        checkOutput({tag, "_lives"}, int'(lives), MAX_LIVES);
        checkOutput({tag, "_time_left"}, int'(time_left), 0);
        checkOutput({tag, "_pulses"}, int'({new_round, hit, miss}), 0);
        checkOutput({tag, "_game_over"}, int'(game_over), 0);
`ifdef ROUND_SCORER_STREAK_EN
        checkOutput({tag, "_streak"}, int'(streak), 0);
`endif
    endtask

    task automatic applyReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        modelNewGame();
    endtask

    task automatic pressButton(input bit isSubmit);
        if (isSubmit) submit = 1'b1; else start = 1'b1;
        repeat (3) @(negedge clk);
        if (isSubmit) submit = 1'b0; else start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulseTick();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic waitOutcome(input int h0, input int m0, output bit gotHit);
        int c = 0;
        while (hitCount == h0 && missCount == m0 && c < 60) begin
            @(negedge clk);
            c++;
        end
        gotHit = (hitCount != h0);
        if (hitCount == h0 && missCount == m0) checkOutput("outcome_seen", 0, 1);
    endtask

    task automatic waitNewRound(input int n0);
        int c = 0;
        while (nrCount == n0 && c < 60) begin
            @(negedge clk);
            c++;
        end
        checkOutput("new_round_seen", int'(nrCount != n0), 1);
        checkOutput("play_state", int'(state), 2);
        checkOutput("time_left_loaded", int'(time_left), ROUND_TICKS);
    endtask

    task automatic startGame();
        int n0 = nrCount;
        pressButton(1'b0);
        waitNewRound(n0);
        repeat (3) @(negedge clk);
        checkOutput("new_round_single", nrCount - n0, 1);
        modelNewGame();
    endtask

    // One full round: optional ticks, then submit or let the clock run out; verify against the model.
    task automatic playRound(input logic [2:0] m, input bit useSubmit, input int preTicks,
                             output bit gotHit);
        int h0 = hitCount;
        int m0 = missCount;
        int n0 = nrCount;
        bit expHit = useSubmit && (m == 3'b111);
        if (useSubmit) begin
            for (int i = 0; i < preTicks; i++) begin
                checkOutput("time_left_countdown", int'(time_left), ROUND_TICKS - i);
                pulseTick();
            end
            match = m;
            pressButton(1'b1);
        end else begin
            match = m;
            for (int i = 0; i < ROUND_TICKS; i++) begin
                checkOutput("time_left_countdown", int'(time_left), ROUND_TICKS - i);
                pulseTick();
            end
            checkOutput("time_left_expired", int'(time_left), 0);
        end
        waitOutcome(h0, m0, gotHit);
        modelJudge(expHit);
        checkOutput("hit_vs_miss", int'(gotHit), int'(expHit));
        checkOutput("score", dutScore(), mScore);
        checkOutput("lives", int'(lives), mLives);
        checkOutput("game_over", int'(game_over), int'(mOver));
`ifdef ROUND_SCORER_STREAK_EN
        checkOutput("streak", int'(streak), mStreak);
`endif
        if (mOver) begin
            repeat (3) @(negedge clk);
            checkOutput("over_state", int'(state), 4);
        end else begin
            waitNewRound(n0);
        end
        checkOutput("single_outcome", (hitCount - h0) + (missCount - m0), 1);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        bit gotHit;
        playRound(v.match, v.useSubmit, 0, gotHit);
        checkOutput($sformatf("vec%0d_hit", idx), int'(gotHit), int'(v.expHit));
        checkOutput($sformatf("vec%0d_score", idx), dutScore(), v.expScore);
        checkOutput($sformatf("vec%0d_lives", idx), int'(lives), v.expLives);
    endtask

    task automatic overIgnoresSubmit();
        int h0 = hitCount;
        int m0 = missCount;
        int s0 = dutScore();
        pressButton(1'b1);
        checkOutput("over_submit_state", int'(state), 4);
        checkOutput("over_submit_score", dutScore(), s0);
        checkOutput("over_submit_outcomes", (hitCount - h0) + (missCount - m0), 0);
        checkOutput("over_level", int'(game_over), 1);
    endtask

    task automatic restartFromOver();
        int n0 = nrCount;
        pressButton(1'b0);
        waitNewRound(n0);
        modelNewGame();
        checkOutput("restart_score", dutScore(), 0);
        checkOutput("restart_lives", int'(lives), MAX_LIVES);
        checkOutput("restart_game_over", int'(game_over), 0);
    endtask

    initial begin
        int  h0, m0, n0;
        bit  gotHit;
        logic [2:0] m;
        bit  useSub;
        int  pre;

        vecs[0] = '{3'b111, 1'b1, 1'b1, 1, 3};
        vecs[1] = '{3'b111, 1'b1, 1'b1, 2, 3};
        vecs[2] = '{3'b101, 1'b1, 1'b0, 2, 2};
        vecs[3] = '{3'b111, 1'b0, 1'b0, 2, 1};
        vecs[4] = '{3'b111, 1'b1, 1'b1, 3, 1};
        vecs[5] = '{3'b011, 1'b1, 1'b0, 3, 0};

        applyReset();
        startGame();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);
        checkOutput("table_ends_over", int'(game_over), 1);
        overIgnoresSubmit();
        restartFromOver();

        // Submit event and final tick land in the same cycle: must be judged as a submit.
        h0 = hitCount;
        m0 = missCount;
        n0 = nrCount;
        match = 3'b000;
        for (int i = 0; i < ROUND_TICKS - 1; i++) pulseTick();
        checkOutput("time_left_before_race", int'(time_left), 1);
        match = 3'b111;
        submit = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        submit = 1'b0;
        waitOutcome(h0, m0, gotHit);
        modelJudge(1'b1);
        checkOutput("race_hit", int'(gotHit), 1);
        checkOutput("race_lives", int'(lives), mLives);
        checkOutput("race_score", dutScore(), mScore);
        waitNewRound(n0);
        repeat (15) @(negedge clk);
        checkOutput("race_no_timeout_miss", missCount - m0, 0);

        for (int r = 0; r < 50; r++) begin
            if (mOver) begin
                overIgnoresSubmit();
                restartFromOver();
            end else begin
                if ($urandom_range(0, 5) == 0) begin
                    h0 = hitCount;
                    m0 = missCount;
                    pressButton(1'b0);
                    checkOutput("start_ignored_in_play", int'(state), 2);
                    checkOutput("start_no_outcome", (hitCount - h0) + (missCount - m0), 0);
                end
                match  = 3'($urandom_range(0, 7));
                m      = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 6));
                useSub = ($urandom_range(0, 4) != 0);
                pre    = $urandom_range(0, ROUND_TICKS - 2);
                playRound(m, useSub, pre, gotHit);
            end
        end

        applyReset();
        startGame();
        for (int i = 0; i < 150 && mScore < 99; i++) playRound(3'b111, 1'b1, 0, gotHit);
        checkOutput("sat_reached_ones", int'(score_ones), 9);
        checkOutput("sat_reached_tens", int'(score_tens), 9);
        playRound(3'b111, 1'b1, 0, gotHit);
        playRound(3'b111, 1'b1, 0, gotHit);
        checkOutput("sat_hold", dutScore(), 99);

        // Reset mid-round with both buttons held: neither may fire until released.
        submit = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("midreset");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("held_start_ignored", int'(state), 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        h0 = hitCount;
        m0 = missCount;
        n0 = nrCount;
        pressButton(1'b0);
        waitNewRound(n0);
        modelNewGame();
        repeat (8) @(negedge clk);
        checkOutput("held_submit_ignored", (hitCount - h0) + (missCount - m0), 0);
        checkOutput("held_submit_state", int'(state), 2);
        submit = 1'b0;
        repeat (3) @(negedge clk);
        playRound(3'b111, 1'b1, 0, gotHit);
        checkOutput("after_repress_score", dutScore(), 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
